msgpass_raddr_gen: RTL and testbench

MSGPASS_RADDR_GEN -- requirements
Module: msgpass_raddr_gen

---
 rtl/msgPass_config_pkg.sv | 20 ++
 rtl/msgpass_base_table.sv | 31 +++
 rtl/msgpass_raddr_gen.sv | 116 +++++++++++
 tb/tb_msgpass_raddr_gen.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/msgPass_config_pkg.sv
// Shared configuration for the message-pass read-address generator:
// FSM state encoding, default geometry and DRC flag positions.
package msgPass_config_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } raddr_state_e;

  localparam int ADDR_W_DEF   = 8;
  localparam int OFS_W_DEF    = 6;
  localparam int BASE_NUM_DEF = 4;
  localparam int DRC_NUM_DEF  = 2;
  localparam int DRC_STEP_DEF = 2;

  // Bit of is_drc_i that selects the strided (DRC1) offset increment.
  localparam int DRC1_IDX = 1;

endpackage

// File: rtl/msgpass_base_table.sv
// Base-address register file: one synchronous write port, combinational read.
// Zero latency on read, a write is visible the cycle after it is issued; no backpressure.
module msgpass_base_table #(
  parameter int ADDR_W   = 8,
  parameter int BASE_NUM = 4
) (
  input  logic                        sys_clk,
  input  logic                        rstn,
  input  logic                        wr_en_i,
  input  logic [$clog2(BASE_NUM)-1:0] wr_idx_i,
  input  logic [ADDR_W-1:0]           wr_data_i,
  input  logic [$clog2(BASE_NUM)-1:0] rd_idx_i,
  output logic [ADDR_W-1:0]           rd_data_o
);

  logic [ADDR_W-1:0] mem_q [BASE_NUM];

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < BASE_NUM; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // A read in the same cycle as a write to that entry returns the old value.
  assign rd_data_o = mem_q[rd_idx_i];

endmodule

// File: rtl/msgpass_raddr_gen.sv
// Burst read-address generator: base + stepped offset, one address per handshake.
// First address valid the cycle after start; addr_o holds while addr_ready_i is low.
module msgpass_raddr_gen
  import msgPass_config_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int OFS_W    = OFS_W_DEF,
  parameter int BASE_NUM = BASE_NUM_DEF,
  parameter int DRC_NUM  = DRC_NUM_DEF,
  parameter int DRC_STEP = DRC_STEP_DEF
) (
  input  logic                        sys_clk,
  input  logic                        rstn,
  input  logic                        start_i,
  input  logic                        stop_i,
  input  logic [$clog2(BASE_NUM)-1:0] base_sel_i,
  input  logic [OFS_W-1:0]            len_i,
  input  logic [DRC_NUM-1:0]          is_drc_i,
  input  logic                        base_wr_en_i,
  input  logic [$clog2(BASE_NUM)-1:0] base_wr_idx_i,
  input  logic [ADDR_W-1:0]           base_wr_data_i,
  output logic [ADDR_W-1:0]           addr_o,
  output logic                        addr_valid_o,
  input  logic                        addr_ready_i,
  output logic                        busy_o,
  output logic                        done_o
);

  raddr_state_e       state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [OFS_W-1:0]   offset_q, offset_d;
  logic [OFS_W:0]     remaining_q, remaining_d;
  logic [OFS_W-1:0]   step_q, step_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [ADDR_W-1:0]  tbl_rd_data;
  logic [OFS_W-1:0]   offset_next;
  logic               unused_drc;

  msgpass_base_table #(
    .ADDR_W   (ADDR_W),
    .BASE_NUM (BASE_NUM)
  ) u_base_table (
    .sys_clk   (sys_clk),
    .rstn      (rstn),
    .wr_en_i   (base_wr_en_i),
    .wr_idx_i  (base_wr_idx_i),
    .wr_data_i (base_wr_data_i),
    .rd_idx_i  (base_sel_i),
    .rd_data_o (tbl_rd_data)
  );

  // Only the DRC1 flag changes addressing; other flags are accepted but unused.
  assign unused_drc  = ^is_drc_i;
  assign offset_next = offset_q + step_q;

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    offset_d    = offset_q;
    remaining_d = remaining_q;
    step_d      = step_q;
    addr_d      = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i && !stop_i) begin
          state_d     = ST_RUN;
          base_d      = tbl_rd_data;
          offset_d    = '0;
          remaining_d = (len_i == '0) ? {1'b1, {OFS_W{1'b0}}} : {1'b0, len_i};
          step_d      = is_drc_i[DRC1_IDX] ? OFS_W'(DRC_STEP) : OFS_W'(1);
          addr_d      = tbl_rd_data;
        end
      end
      ST_RUN: begin
        if (stop_i) begin
          state_d = ST_IDLE;
        end else if (addr_ready_i) begin
          offset_d    = offset_next;
          remaining_d = remaining_q - (OFS_W + 1)'(1);
          // The final address stays on addr_o through DONE and IDLE.
          if (remaining_q == (OFS_W + 1)'(1)) begin
            state_d = ST_DONE;
          end else begin
            addr_d = base_q + ADDR_W'(offset_next);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      offset_q    <= '0;
      remaining_q <= '0;
      step_q      <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      offset_q    <= offset_d;
      remaining_q <= remaining_d;
      step_q      <= step_d;
      addr_q      <= addr_d;
    end
  end

  assign addr_o       = addr_q;
  assign addr_valid_o = (state_q == ST_RUN);
  assign busy_o       = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done_o       = (state_q == ST_DONE);

endmodule

// File: tb/tb_msgpass_raddr_gen.sv
// Scoreboard bench for msgpass_raddr_gen: stimulus pushes expected addresses and
// a done marker per burst; a negedge monitor pops them on each handshake / done_o.
module tb_msgpass_raddr_gen;

  logic       sys_clk = 1'b0;
  logic       rstn;
  logic       start_i, stop_i;
  logic [1:0] base_sel_i;
  logic [5:0] len_i;
  logic [1:0] is_drc_i;
  logic       base_wr_en_i;
  logic [1:0] base_wr_idx_i;
  logic [7:0] base_wr_data_i;
  logic [7:0] addr_o;
  logic       addr_valid_o, addr_ready_i, busy_o, done_o;

  msgpass_raddr_gen dut (
    .sys_clk        (sys_clk),
    .rstn           (rstn),
    .start_i        (start_i),
    .stop_i         (stop_i),
    .base_sel_i     (base_sel_i),
    .len_i          (len_i),
    .is_drc_i       (is_drc_i),
    .base_wr_en_i   (base_wr_en_i),
    .base_wr_idx_i  (base_wr_idx_i),
    .base_wr_data_i (base_wr_data_i),
    .addr_o         (addr_o),
    .addr_valid_o   (addr_valid_o),
    .addr_ready_i   (addr_ready_i),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];        // expected addresses; -1 marks the expected done_o pulse
  int tbl[4];          // reference copy of the base table
  int hs_cnt = 0;
  int cyc = 0;
  int last_hs_cyc = -10;
  bit hold_vld = 0;
  int hold_addr = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every DUT handshake and done pulse against the scoreboard.
  always @(negedge sys_clk) begin
    if (!rstn) begin
      hold_vld = 0;
    end else begin
      cyc++;
      if (addr_valid_o && hold_vld) chk("hold", int'(addr_o), hold_addr);
      hold_vld  = addr_valid_o && !addr_ready_i;
      hold_addr = int'(addr_o);
      if (addr_valid_o && addr_ready_i) begin
        if (exp_q.size() == 0 || exp_q[0] < 0) begin
          chk("unexpected_handshake", 1, 0);
        end else begin
          chk("addr", int'(addr_o), exp_q.pop_front());
          hs_cnt++;
          last_hs_cyc = cyc;
        end
      end
      if (done_o) begin
        if (exp_q.size() == 0 || exp_q[0] >= 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          void'(exp_q.pop_front());
          chk("done_timing", cyc, last_hs_cyc + 1);
        end
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic write_base(input int idx, input int data);
    base_wr_en_i   = 1'b1;
    base_wr_idx_i  = 2'(idx);
    base_wr_data_i = 8'(data);
    tbl[idx]       = data & 8'hff;
    tick();
    base_wr_en_i = 1'b0;
  endtask

  // mode: 0 ready always 1, 1 random ready, 2 ready pattern 1,0,0,1
  // wr: 0 none, 1 random writes, 2 write the active index early in the burst
  task automatic run_burst(input int sel, input int len, input int drc, input int mode,
                           input int stop_after, input bit wr_same, input int wr,
                           input bit start_mid);
    int n, base, step, budget, hs0, k, idx;
    base = tbl[sel];
    n    = (len == 0) ? 64 : len;
    step = ((drc & 2) != 0) ? 2 : 1;
    for (int j = 0; j < n; j++) exp_q.push_back((base + ((j * step) % 64)) % 256);
    exp_q.push_back(-1);
    start_i      = 1'b1;
    base_sel_i   = 2'(sel);
    len_i        = 6'(len);
    is_drc_i     = 2'(drc);
    addr_ready_i = 1'b0;
    if (wr_same) write_base(sel, $urandom_range(0, 255));
    else tick();
    start_i = 1'b0;
    chk("first_valid", int'(addr_valid_o), 1);
    hs0 = hs_cnt;
    budget = 0;
    k = 0;
    while (exp_q.size() != 0 && budget < 400) begin
      budget++;
      if (stop_after > 0 && hs_cnt - hs0 == stop_after) begin
        addr_ready_i = 1'b0;
        stop_i  = 1'b1;
        start_i = 1'b1;
        tick();
        stop_i  = 1'b0;
        start_i = 1'b0;
        exp_q.delete();
        chk("stop_valid", int'(addr_valid_o), 0);
        chk("stop_busy", int'(busy_o), 0);
        break;
      end
      case (mode)
        0: addr_ready_i = 1'b1;
        1: addr_ready_i = 1'($urandom_range(0, 1));
        default: addr_ready_i = (k % 4 == 0) || (k % 4 == 3);
      endcase
      if (start_mid && k == 2) begin
        start_i    = 1'b1;
        base_sel_i = 2'((sel + 1) % 4);
        len_i      = 6'd1;
        is_drc_i   = ~2'(drc);
      end
      if ((wr == 2 && k == 1) || (wr == 1 && $urandom_range(0, 2) == 0)) begin
        idx = (wr == 2) ? sel : $urandom_range(0, 3);
        base_wr_en_i   = 1'b1;
        base_wr_idx_i  = 2'(idx);
        base_wr_data_i = 8'($urandom_range(0, 255));
        tbl[idx]       = int'(base_wr_data_i);
      end
      k++;
      tick();
      start_i      = 1'b0;
      base_wr_en_i = 1'b0;
    end
    if (budget >= 400) chk("burst_timeout", 1, 0);
    addr_ready_i = 1'b0;
    chk("idle_busy", int'(busy_o), 0);
    if (stop_after == 0 || stop_after >= n) chk("hs_count", hs_cnt - hs0, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    start_i = 0; stop_i = 0; base_sel_i = 0; len_i = 0; is_drc_i = 0;
    base_wr_en_i = 0; base_wr_idx_i = 0; base_wr_data_i = 0; addr_ready_i = 0;
    for (int i = 0; i < 4; i++) tbl[i] = 0;
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_addr", int'(addr_o), 0);
    chk("rst_valid", int'(addr_valid_o), 0);
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    rstn = 1'b1;
    tick();

    write_base(2, 8'h40);
    run_burst(2, 4, 0, 0, 0, 0, 0, 0);
    write_base(1, 8'h10);
    run_burst(1, 4, 2, 0, 0, 0, 0, 0);
    run_burst(2, 4, 0, 2, 0, 0, 0, 0);
    write_base(0, 8'hF8);
    run_burst(0, 0, 0, 0, 0, 0, 0, 0);
    chk("wrap_last_addr", int'(addr_o), 8'h37);
    run_burst(2, 6, 0, 0, 2, 0, 0, 0);
    tick();
    chk("post_stop_done", int'(done_o), 0);
    run_burst(3, 5, 1, 0, 0, 0, 0, 1);
    run_burst(2, 4, 0, 0, 0, 0, 2, 0);
    run_burst(2, 3, 0, 0, 0, 0, 0, 0);
    run_burst(1, 3, 0, 0, 0, 1, 0, 0);

    for (int b = 0; b < 30; b++) begin
      run_burst($urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 12),
                $urandom_range(0, 3), $urandom_range(0, 2),
                ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0,
                1'($urandom_range(0, 1)), 1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset in the middle of a burst aborts it silently.
    for (int j = 0; j < 8; j++) exp_q.push_back((tbl[2] + j) % 256);
    exp_q.push_back(-1);
    start_i = 1'b1; base_sel_i = 2'd2; len_i = 6'd8; is_drc_i = 2'd0;
    tick();
    start_i = 1'b0;
    addr_ready_i = 1'b1;
    repeat (2) tick();
    rstn = 1'b0;
    #1;
    exp_q.delete();
    for (int i = 0; i < 4; i++) tbl[i] = 0;
    chk("midrst_addr", int'(addr_o), 0);
    chk("midrst_valid", int'(addr_valid_o), 0);
    chk("midrst_busy", int'(busy_o), 0);
    chk("midrst_done", int'(done_o), 0);
    tick();
    rstn = 1'b1;
    repeat (3) begin
      tick();
      chk("no_restart", int'(addr_valid_o), 0);
    end
    addr_ready_i = 1'b0;
    run_burst(2, 2, 0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
